ddr3_stream_writer: RTL and testbench

- Upstream stage of the DDR3 MIG user interface; clocked in the MIG ui_clk domain.
- Accepts a 32-bit word stream (frame data from the detection pipeline) and buffers it in a small FIFO.
- Packs word pairs into BL8 bursts (2 app beats × 32 bits = 8 × DQ8) and issues sequential write commands from a programmable base address.
- Wraps the address at end of frame and pulses frame_done.

---
 rtl/ddr3_wr_pkg.sv | 19 +
 rtl/ddr3_wr_fifo.sv | 52 +++++
 rtl/ddr3_stream_writer.sv | 198 +++++++++++++++++++
 tb/tb_ddr3_stream_writer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_wr_pkg.sv
// Shared types and constants for the DDR3 stream writer: FSM state encoding,
// MIG command codes and write-data byte masks.
package ddr3_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_PAD  = 3'd3,
        ST_CMD  = 3'd4
    } wr_state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [3:0] MASK_NONE = 4'h0;
    localparam logic [3:0] MASK_ALL  = 4'hF;

endpackage

// File: rtl/ddr3_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags; the head
// entry is visible on o_rd_data whenever o_empty is low.
module ddr3_wr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ddr3_stream_writer.sv
// Packs a 32-bit word stream into BL8 MIG write bursts at sequential addresses.
// Define DDR3_WR_STATS_EN to add saturating burst/stall counters.
module ddr3_stream_writer
    import ddr3_wr_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 28,
    parameter int LEN_W      = 20,
    parameter int ADDR_STEP  = 8
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              init_calib_complete,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_frame_bursts,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [31:0]       app_wdf_data,
    output logic [3:0]        app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
`ifdef DDR3_WR_STATS_EN
    output logic [31:0]       stat_bursts,
    output logic [31:0]       stat_cmd_stall,
    output logic [31:0]       stat_wdf_stall,
`endif
    output logic              frame_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    wr_state_t         r_state;
    logic [ADDR_W-1:0] r_offset;
    logic [LEN_W-1:0]  r_burst_cnt;
    logic              r_burst_last;
    logic              r_frame_done;

    logic              w_full;
    logic              w_empty;
    logic [32:0]       w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_wdf_acc;
    logic              w_cmd_acc;
    logic [LEN_W-1:0]  w_burst_cnt_nx;
    logic              w_frame_end;

    // Reset is folded in so the stream sees no ready while the block is held.
    assign s_ready   = !w_full && init_calib_complete && !ui_clk_sync_rst;
    assign w_push    = s_valid && s_ready;
    assign w_wdf_acc = app_wdf_wren && app_wdf_rdy;
    assign w_cmd_acc = app_en && app_rdy;
    assign w_pop     = w_wdf_acc && ((r_state == ST_W0) || (r_state == ST_W1));

    assign w_burst_cnt_nx = r_burst_cnt + LEN_W'(1);
    assign w_frame_end    = r_burst_last ||
                            ((cfg_frame_bursts != '0) && (w_burst_cnt_nx == cfg_frame_bursts));

    ddr3_wr_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (ui_clk),
        .i_rst     (ui_clk_sync_rst),
        .i_wr_en   (w_push),
        .i_wr_data ({s_last, s_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        app_wdf_wren = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = MASK_NONE;
        app_wdf_end  = 1'b0;
        app_en       = 1'b0;
        case (r_state)
            ST_W0: begin
                app_wdf_wren = 1'b1;
                app_wdf_data = w_head[31:0];
            end
            // The second word may not have arrived yet; hold off until it does.
            ST_W1: begin
                app_wdf_wren = !w_empty;
                app_wdf_end  = !w_empty;
                app_wdf_data = w_empty ? 32'd0 : w_head[31:0];
            end
            ST_PAD: begin
                app_wdf_wren = 1'b1;
                app_wdf_mask = MASK_ALL;
                app_wdf_end  = 1'b1;
            end
            ST_CMD: begin
                app_en = 1'b1;
            end
            default: begin
                app_en = 1'b0;
            end
        endcase
    end

    assign app_addr   = cfg_base_addr + r_offset;
    assign app_cmd    = CMD_WRITE;
    assign frame_done = r_frame_done;
    assign busy       = !w_empty || (r_state != ST_IDLE);

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            r_state      <= ST_IDLE;
            r_offset     <= '0;
            r_burst_cnt  <= '0;
            r_burst_last <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && init_calib_complete) begin
                        r_state <= ST_W0;
                    end
                end
                ST_W0: begin
                    if (w_wdf_acc) begin
                        r_burst_last <= w_head[32];
                        r_state      <= w_head[32] ? ST_PAD : ST_W1;
                    end
                end
                ST_W1: begin
                    if (w_wdf_acc) begin
                        r_burst_last <= w_head[32];
                        r_state      <= ST_CMD;
                    end
                end
                ST_PAD: begin
                    if (w_wdf_acc) begin
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_cmd_acc) begin
                        r_state <= ST_IDLE;
                        if (w_frame_end) begin
                            r_offset     <= '0;
                            r_burst_cnt  <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_offset    <= r_offset + STEP;
                            r_burst_cnt <= w_burst_cnt_nx;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DDR3_WR_STATS_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_cmd_stall;
    logic [31:0] r_stat_wdf_stall;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            r_stat_bursts    <= '0;
            r_stat_cmd_stall <= '0;
            r_stat_wdf_stall <= '0;
        end else begin
            if (w_cmd_acc && (r_stat_bursts != '1)) begin
                r_stat_bursts <= r_stat_bursts + 32'd1;
            end
            if ((r_state == ST_CMD) && !app_rdy && (r_stat_cmd_stall != '1)) begin
                r_stat_cmd_stall <= r_stat_cmd_stall + 32'd1;
            end
            if (app_wdf_wren && !app_wdf_rdy && (r_stat_wdf_stall != '1)) begin
                r_stat_wdf_stall <= r_stat_wdf_stall + 32'd1;
            end
        end
    end

    assign stat_bursts    = r_stat_bursts;
    assign stat_cmd_stall = r_stat_cmd_stall;
    assign stat_wdf_stall = r_stat_wdf_stall;
`endif

endmodule

// File: tb/tb_ddr3_stream_writer.sv
// Self-checking bench for ddr3_stream_writer: a word-level burst model feeds a
// per-cycle compare process, plus literal address/frame expectations per scenario.
module tb_ddr3_stream_writer;

    localparam int ADDR_W = 28;
    localparam int LEN_W  = 20;

    logic              ui_clk = 1'b0;
    logic              ui_clk_sync_rst;
    logic              init_calib_complete;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [LEN_W-1:0]  cfg_frame_bursts;
    logic [31:0]       s_data;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [31:0]       app_wdf_data;
    logic [3:0]        app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy = 1'b1;
    logic              frame_done;
    logic              busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int wdfMode     = 0;

    always #5 ui_clk = ~ui_clk;

    ddr3_stream_writer dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_frame_bursts    (cfg_frame_bursts),
        .s_data              (s_data),
        .s_last              (s_last),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .frame_done          (frame_done),
        .busy                (busy)
    );

    // Data-ready pattern: 0 = always ready, 1 = toggling, 2 = never ready.
    always @(posedge ui_clk) begin
        #1;
        case (wdfMode)
            0:       app_wdf_rdy = 1'b1;
            1:       app_wdf_rdy = ~app_wdf_rdy;
            default: app_wdf_rdy = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: bursts are derived from pushed words alone.
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        e;
    } beat_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              fd;
    } cmd_t;

    beat_t             beatQ[$];
    cmd_t              cmdQ[$];
    logic [ADDR_W-1:0] addrLog[$];
    logic [31:0]       endLog[$];
    int                fdCount  = 0;
    int                padCount = 0;

    bit                haveFirst = 1'b0;
    logic [ADDR_W-1:0] mOffset   = '0;
    int                mCnt      = 0;
    bit                fdNext    = 1'b0;
    bit                prevWdfStall = 1'b0;
    bit                prevCmdStall = 1'b0;
    beat_t             prevBeat;
    logic [ADDR_W-1:0] prevAddr;
    beat_t             mb;
    cmd_t              mc;

    function void completeBurst(input bit lastFlag);
        cmd_t c;
        c.a = cfg_base_addr + mOffset;
        mCnt++;
        c.fd = lastFlag || ((cfg_frame_bursts != 0) && (mCnt == int'(cfg_frame_bursts)));
        cmdQ.push_back(c);
        if (c.fd) begin
            mOffset = '0;
            mCnt    = 0;
        end else begin
            mOffset = mOffset + 28'd8;
        end
    endfunction

    function void modelPush(input logic [31:0] d, input logic l);
        if (!haveFirst) begin
            beatQ.push_back({d, 4'h0, 1'b0});
            if (l) begin
                beatQ.push_back({32'd0, 4'hF, 1'b1});
                completeBurst(1'b1);
            end else begin
                haveFirst = 1'b1;
            end
        end else begin
            beatQ.push_back({d, 4'h0, 1'b1});
            haveFirst = 1'b0;
            completeBurst(l);
        end
    endfunction

    always @(negedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            beatQ.delete();
            cmdQ.delete();
            haveFirst    = 1'b0;
            mOffset      = '0;
            mCnt         = 0;
            fdNext       = 1'b0;
            prevWdfStall = 1'b0;
            prevCmdStall = 1'b0;
        end else begin
            checkOutput("frame_done", frame_done, fdNext);
            fdNext = 1'b0;
            if (frame_done) fdCount++;
            if (s_valid && s_ready) modelPush(s_data, s_last);
            if (prevWdfStall) begin
                checkOutput("wren_hold", app_wdf_wren, 1);
                checkOutput("wdf_payload_hold", {app_wdf_data, app_wdf_mask, app_wdf_end}, prevBeat);
            end
            if (prevCmdStall) begin
                checkOutput("en_hold", app_en, 1);
                checkOutput("addr_hold", app_addr, prevAddr);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (beatQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", app_wdf_data);
                end else begin
                    mb = beatQ.pop_front();
                    checkOutput("wdf_beat", {app_wdf_data, app_wdf_mask, app_wdf_end}, mb);
                    if (app_wdf_end) endLog.push_back(app_wdf_data);
                    if (app_wdf_mask == 4'hF) padCount++;
                end
            end
            prevWdfStall = app_wdf_wren && !app_wdf_rdy;
            prevBeat     = {app_wdf_data, app_wdf_mask, app_wdf_end};
            if (app_en) checkOutput("app_cmd", app_cmd, 3'b000);
            if (app_en && app_rdy) begin
                if (cmdQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_cmd: got addr 0x%0h, expected no command", app_addr);
                end else begin
                    mc = cmdQ.pop_front();
                    checkOutput("cmd_addr", app_addr, mc.a);
                    addrLog.push_back(app_addr);
                    fdNext = mc.fd;
                end
            end
            prevCmdStall = app_en && !app_rdy;
            prevAddr     = app_addr;
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        int n  = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!ok && n < 64) begin
            @(negedge ui_clk);
            ok = s_ready;
            @(posedge ui_clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("push_accepted", ok, 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy || beatQ.size() != 0 || cmdQ.size() != 0) && n < budget) begin
            @(posedge ui_clk);
            #1;
            n++;
        end
        checkOutput("drain_in_time", n < budget, 1);
        repeat (2) begin
            @(posedge ui_clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, f0, e0, p0, n;
        ui_clk_sync_rst     = 1'b1;
        init_calib_complete = 1'b0;
        cfg_base_addr       = 28'h100;
        cfg_frame_bursts    = '0;
        s_valid             = 1'b0;
        s_data              = '0;
        s_last              = 1'b0;
        app_rdy             = 1'b1;
        repeat (3) @(posedge ui_clk);
        #1 ui_clk_sync_rst = 1'b0;

        // Reset state
        @(negedge ui_clk);
        checkOutput("rst_app_en", app_en, 0);
        checkOutput("rst_wren", app_wdf_wren, 0);
        checkOutput("rst_wdf_fields", {app_wdf_data, app_wdf_mask, app_wdf_end}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_app_addr", app_addr, 28'h100);

        // Calibration low blocks everything
        @(posedge ui_clk);
        #1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge ui_clk);
            checkOutput("nocal_s_ready", s_ready, 0);
            checkOutput("nocal_app_en", app_en, 0);
            checkOutput("nocal_wren", app_wdf_wren, 0);
        end
        @(posedge ui_clk);
        #1;
        s_valid = 1'b0;
        init_calib_complete = 1'b1;

        // Four words, last on the fourth: two full bursts
        a0 = addrLog.size(); f0 = fdCount; e0 = endLog.size();
        for (int i = 0; i < 4; i++) applyStimulus(32'hA000_0000 + i, i == 3);
        waitIdle(100);
        checkOutput("t2_nbursts", addrLog.size() - a0, 2);
        checkOutput("t2_addr0", addrLog[a0], 28'h100);
        checkOutput("t2_addr1", addrLog[a0 + 1], 28'h108);
        checkOutput("t2_end0", endLog[e0], 32'hA000_0001);
        checkOutput("t2_end1", endLog[e0 + 1], 32'hA000_0003);
        checkOutput("t2_frame_done", fdCount - f0, 1);

        // Three words, last on the third: padded second burst; also latency
        a0 = addrLog.size(); f0 = fdCount; e0 = endLog.size(); p0 = padCount;
        applyStimulus(32'hB000_0000, 1'b0);
        @(negedge ui_clk);
        checkOutput("lat_cycle1_wren", app_wdf_wren, 0);
        @(negedge ui_clk);
        checkOutput("lat_cycle2_wren", app_wdf_wren, 1);
        checkOutput("lat_cycle2_data", app_wdf_data, 32'hB000_0000);
        @(posedge ui_clk);
        #1;
        applyStimulus(32'hB000_0001, 1'b0);
        applyStimulus(32'hB000_0002, 1'b1);
        waitIdle(100);
        checkOutput("t3_addr0", addrLog[a0], 28'h100);
        checkOutput("t3_addr1", addrLog[a0 + 1], 28'h108);
        checkOutput("t3_end_pad", endLog[e0 + 1], 32'd0);
        checkOutput("t3_pad_count", padCount - p0, 1);
        checkOutput("t3_frame_done", fdCount - f0, 1);

        // Frame length of two bursts, no s_last
        cfg_frame_bursts = 20'd2;
        a0 = addrLog.size(); f0 = fdCount;
        for (int i = 0; i < 6; i++) applyStimulus(32'hC000_0000 + i, 1'b0);
        waitIdle(100);
        checkOutput("t4_nbursts", addrLog.size() - a0, 3);
        checkOutput("t4_addr0", addrLog[a0], 28'h100);
        checkOutput("t4_addr1", addrLog[a0 + 1], 28'h108);
        checkOutput("t4_addr2", addrLog[a0 + 2], 28'h100);
        checkOutput("t4_frame_done", fdCount - f0, 1);

        // Command stall with toggling data ready; frame continues from offset 8
        cfg_frame_bursts = '0;
        wdfMode = 1;
        app_rdy = 1'b0;
        a0 = addrLog.size(); f0 = fdCount;
        for (int i = 0; i < 4; i++) applyStimulus(32'hD000_0000 + i, 1'b0);
        n = 0;
        while (!app_en && n < 50) begin
            @(negedge ui_clk);
            n++;
        end
        checkOutput("t5_reach_cmd", app_en, 1);
        repeat (10) @(negedge ui_clk);
        @(posedge ui_clk);
        #1;
        app_rdy = 1'b1;
        applyStimulus(32'hD000_0004, 1'b1);
        waitIdle(200);
        wdfMode = 0;
        checkOutput("t5_nbursts", addrLog.size() - a0, 3);
        checkOutput("t5_addr0", addrLog[a0], 28'h108);
        checkOutput("t5_addr1", addrLog[a0 + 1], 28'h110);
        checkOutput("t5_addr2", addrLog[a0 + 2], 28'h118);
        checkOutput("t5_frame_done", fdCount - f0, 1);

        // Fill the FIFO while data ready is withheld
        @(posedge ui_clk);
        #1;
        wdfMode = 2;
        @(posedge ui_clk);
        #1;
        a0 = addrLog.size(); f0 = fdCount;
        for (int i = 0; i < 16; i++) applyStimulus(32'hE000_0000 + i, i == 15);
        @(negedge ui_clk);
        checkOutput("t6_full_s_ready", s_ready, 0);
        checkOutput("t6_head_wren", app_wdf_wren, 1);
        checkOutput("t6_head_data", app_wdf_data, 32'hE000_0000);
        @(posedge ui_clk);
        #1;
        wdfMode = 0;
        waitIdle(200);
        checkOutput("t6_nbursts", addrLog.size() - a0, 8);
        checkOutput("t6_addr_last", addrLog[a0 + 7], 28'h138);
        checkOutput("t6_frame_done", fdCount - f0, 1);

        // Reset while waiting for the second word of a burst
        applyStimulus(32'hF000_0000, 1'b0);
        applyStimulus(32'hF000_0001, 1'b0);
        applyStimulus(32'hF000_0002, 1'b0);
        repeat (6) @(negedge ui_clk);
        checkOutput("t7_in_w1_wren", app_wdf_wren, 0);
        checkOutput("t7_in_w1_busy", busy, 1);
        #2 ui_clk_sync_rst = 1'b1;
        #1;
        checkOutput("t7_rst_app_en", app_en, 0);
        checkOutput("t7_rst_wdf", {app_wdf_wren, app_wdf_end, app_wdf_mask, app_wdf_data}, 0);
        checkOutput("t7_rst_busy", busy, 0);
        checkOutput("t7_rst_s_ready", s_ready, 0);
        checkOutput("t7_rst_frame_done", frame_done, 0);
        checkOutput("t7_rst_addr", app_addr, 28'h100);
        repeat (2) @(posedge ui_clk);
        #1 ui_clk_sync_rst = 1'b0;
        a0 = addrLog.size(); f0 = fdCount;
        applyStimulus(32'h1234_0000, 1'b0);
        applyStimulus(32'h1234_0001, 1'b1);
        waitIdle(100);
        checkOutput("t7_nbursts", addrLog.size() - a0, 1);
        checkOutput("t7_addr0", addrLog[a0], 28'h100);
        checkOutput("t7_frame_done", fdCount - f0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
